// File: rtl/demux_pkg.sv
// Shared types and defaults for the serial-to-parallel slot demultiplexer.
package demux_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int N_DEFAULT     = 8;
   localparam int SEL_W_DEFAULT = 3;

   // Ceiling log2, used to confirm that the slot counter width matches the lane count.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : demux_pkg

// File: rtl/demux_1to8_seq_slot_counter.sv
// Slot index counter: the receive-side equivalent of the transmitter's mux select.
module slot_counter
   import demux_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int SEL_W = SEL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load1_i,
   input  logic             inc_i,
   output logic [SEL_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   // Clear wins over load, load wins over increment; otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load1_i) begin
         cnt_d = SEL_W'(1);
      end else if (inc_i) begin
         cnt_d = cnt_q + SEL_W'(1);
      end
   end

   // Counter register with synchronous reset to slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == LAST);

endmodule : slot_counter

// File: rtl/demux_1to8_seq.sv
// Serial-to-parallel time-division demultiplexer: steers one bit per valid cycle
// into lane[slot] of a staging word and presents completed words on a valid/ready port.
module demux_1to8_seq
   import demux_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int SEL_W = SEL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             frame_start,
   output logic [N-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] slot,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   if ((N < 2) || ((N & (N - 1)) != 0) || (SEL_W != clog2(N))) begin : g_param_check
      $error("demux_1to8_seq: N must be a power of two >= 2 and SEL_W must equal log2(N)");
   end

   state_e           state_q;
   logic [N-1:0]     staging_q;
   logic [N-1:0]     out_data_q;
   logic             out_valid_q;
   logic             frame_err_q;
   logic             overrun_q;

   logic [SEL_W-1:0] slot_q;
   logic             slot_tc;

   logic             accept_start;
   logic             accept_bit;
   logic             word_done;
   logic             cnt_clr;
   logic             cnt_load1;
   logic             cnt_inc;
   logic [N-1:0]     word_d;
   logic [N-1:0]     start_word_d;
   logic             frame_err_d;
   logic             overrun_d;
   logic             load_out_d;

   // Decode this cycle's accept: a frame_start (fresh frame or resync) or a data bit mid-frame.
   always_comb begin
      accept_start = din_valid && frame_start;
      accept_bit   = din_valid && !frame_start && (state_q == SHIFT);
      word_done    = accept_bit && slot_tc;
      cnt_clr      = word_done;
      cnt_load1    = accept_start;
      cnt_inc      = accept_bit && !slot_tc;
      word_d       = {din, staging_q[N-2:0]};
      start_word_d = {{(N-1){1'b0}}, din};
      frame_err_d  = accept_start && (state_q == SHIFT);
      overrun_d    = word_done && out_valid_q && !out_ready;
      load_out_d   = word_done && (!out_valid_q || out_ready);
   end

   slot_counter #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .load1_i (cnt_load1),
      .inc_i   (cnt_inc),
      .cnt_o   (slot_q),
      .tc_o    (slot_tc)
   );

   // Frame FSM, staging word, output holding register and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         staging_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;

         case (state_q)
            IDLE: begin
               // Bits without frame_start are dropped while hunting for sync.
               if (accept_start) begin
                  staging_q <= start_word_d;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (accept_start) begin
                  // Early frame_start: discard the partial word and restart at slot 0.
                  staging_q <= start_word_d;
               end else if (accept_bit) begin
                  if (slot_tc) begin
                     staging_q <= '0;
                     state_q   <= IDLE;
                  end else begin
                     staging_q[slot_q] <= din;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         // A finished word is taken only if the holding register is empty or draining now.
         if (load_out_d) begin
            out_data_q  <= word_d;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign slot      = slot_q;
   assign busy      = (state_q == SHIFT);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule : demux_1to8_seq

// File: tb/tb_demux_1to8_seq.sv
// Directed bench for demux_1to8_seq: reset, framing, gaps, back-to-back frames,
// resync, overrun and mid-frame reset.
module tb_demux_1to8_seq;

   logic       clk;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       frame_start;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] slot;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int errors;
   int checks;

   demux_1to8_seq dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .slot        (slot),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, clock it in, and settle 1 ns past the edge.
   task automatic step(input logic v, input logic fs, input logic d);
      din_valid   = v;
      frame_start = fs;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   // Send an LSB-first frame; optional idle cycles after slots 2 and 5.
   task automatic send_frame(input logic [7:0] w, input bit gaps, input bit ov0);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, (k == 0), w[k]);
         if (k < 7) begin
            chk("slot_step", 32'(slot), 32'(k + 1));
            chk("busy_step", 32'(busy), 32'd1);
            if (ov0) chk("ov_mid", 32'(out_valid), 32'd0);
            if (gaps && (k == 2 || k == 5)) begin
               step(1'b0, 1'b0, 1'b1);
               chk("slot_gap", 32'(slot), 32'(k + 1));
               chk("busy_gap", 32'(busy), 32'd1);
            end
         end else begin
            chk("slot_wrap", 32'(slot), 32'd0);
            chk("busy_end", 32'(busy), 32'd0);
         end
      end
      din_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      din         = 1'b0;
      din_valid   = 1'b0;
      frame_start = 1'b0;
      out_ready   = 1'b1;

      // Reset for two cycles, then five idle cycles.
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_slot", 32'(slot), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_data", 32'(out_data), 32'h00);
      end

      // Basic frame 0x4D (bits 1,0,1,1,0,0,1,0).
      send_frame(8'h4D, 1'b0, 1'b1);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data", 32'(out_data), 32'h4D);
      step(1'b0, 1'b0, 1'b0);
      chk("basic_drop", 32'(out_valid), 32'd0);

      // Same frame with idle gaps after slots 2 and 5.
      send_frame(8'h4D, 1'b1, 1'b1);
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_data", 32'(out_data), 32'h4D);
      step(1'b0, 1'b0, 1'b0);
      chk("gap_drop", 32'(out_valid), 32'd0);

      // Back-to-back frames 0xA5 then 0x3C, no idle cycle between them.
      send_frame(8'hA5, 1'b0, 1'b1);
      chk("b2b_valid0", 32'(out_valid), 32'd1);
      chk("b2b_data0", 32'(out_data), 32'hA5);
      send_frame(8'h3C, 1'b0, 1'b1);
      chk("b2b_valid1", 32'(out_valid), 32'd1);
      chk("b2b_data1", 32'(out_data), 32'h3C);
      step(1'b0, 1'b0, 1'b0);
      chk("b2b_drop", 32'(out_valid), 32'd0);

      // Early resync: frame_start again at slot 4, then a full 0xFF frame.
      w = 8'h0F;
      for (int k = 0; k < 4; k++) step(1'b1, (k == 0), w[k]);
      chk("rs_slot4", 32'(slot), 32'd4);
      step(1'b1, 1'b1, 1'b1);
      chk("rs_ferr", 32'(frame_err), 32'd1);
      chk("rs_slot1", 32'(slot), 32'd1);
      chk("rs_busy", 32'(busy), 32'd1);
      chk("rs_nopart", 32'(out_valid), 32'd0);
      for (int k = 1; k < 8; k++) begin
         step(1'b1, 1'b0, 1'b1);
         chk("rs_ferr_clr", 32'(frame_err), 32'd0);
         if (k < 7) chk("rs_nopart2", 32'(out_valid), 32'd0);
      end
      chk("rs_valid", 32'(out_valid), 32'd1);
      chk("rs_data", 32'(out_data), 32'hFF);
      step(1'b0, 1'b0, 1'b0);

      // Overrun: output stalled while a second word completes.
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0);
      chk("ovr_valid0", 32'(out_valid), 32'd1);
      chk("ovr_data0", 32'(out_data), 32'h11);
      send_frame(8'h22, 1'b0, 1'b0);
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_hold", 32'(out_data), 32'h11);
      chk("ovr_valid1", 32'(out_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("ovr_clear", 32'(overrun), 32'd0);
      chk("ovr_stable", 32'(out_data), 32'h11);
      chk("ovr_valid2", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("ovr_xfer", 32'(out_valid), 32'd0);
      chk("ovr_xfer_data", 32'(out_data), 32'h11);

      // Reset at slot 3 of a new frame; the rest of the frame must not produce output.
      w = 8'hE7;
      for (int k = 0; k < 3; k++) step(1'b1, (k == 0), w[k]);
      chk("mr_slot3", 32'(slot), 32'd3);
      rst = 1'b1;
      step(1'b1, 1'b0, w[3]);
      rst = 1'b0;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_slot", 32'(slot), 32'd0);
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_data", 32'(out_data), 32'h00);
      for (int k = 4; k < 8; k++) begin
         step(1'b1, 1'b0, w[k]);
         chk("mr_tail_valid", 32'(out_valid), 32'd0);
         chk("mr_tail_busy", 32'(busy), 32'd0);
         chk("mr_tail_slot", 32'(slot), 32'd0);
      end
      chk("mr_ferr", 32'(frame_err), 32'd0);
      chk("mr_ovr", 32'(overrun), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_demux_1to8_seq
